// File: rtl/aes_ctr_pkg.sv
// Shared types and helpers for the AES-256 CTR-mode wrapper.
//   ctr_state_e   : job FSM state
//   inc32         : CTR increment (low 32 bits wrap, upper 96 bits fixed)
//   AesLatDefault : default aes_256 pipeline latency
//   DepthDefault  : default plaintext/keystream FIFO depth
package aes_ctr_pkg;

    localparam int unsigned AesLatDefault = 29;
    localparam int unsigned DepthDefault  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } ctr_state_e;

    function automatic logic [127:0] inc32(input logic [127:0] blk);
        return {blk[127:32], blk[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered write and combinational head read.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write wdata_i (ignored when full unless popping in the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   rdata_o      : current head entry
//   empty_o      : no entries
//   count_o      : occupancy, $clog2(Depth)+1 bits
module sync_fifo #(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push-while-full is legal alongside a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/aes_256_ctr_stage.sv
// CTR-mode wrapper around a free-running, fixed-latency aes_256 pipeline.
// Issues one counter block per accepted plaintext, tracks flight with a valid
// shift register, buffers keystream, and emits ciphertext = keystream ^ plaintext.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   start_i, key_i, iv_i,
//   blk_count_i             : job request and its parameters (sampled in IDLE)
//   busy_o, done_o          : job status; done_o pulses once per job
//   pt_valid_i/pt_ready_o/
//   pt_data_i               : plaintext input handshake
//   ct_valid_o/ct_ready_i/
//   ct_data_o               : ciphertext output handshake
//   aes_state_o, aes_key_o  : counter block and key to aes_256
//   aes_out_i               : keystream from aes_256
module aes_256_ctr_stage
    import aes_ctr_pkg::*;
#(
    parameter int unsigned AES_LAT = AesLatDefault,
    parameter int unsigned DEPTH   = DepthDefault
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic [127:0] iv_i,
    input  logic [15:0]  blk_count_i,
    output logic         busy_o,
    output logic         done_o,
    input  logic         pt_valid_i,
    output logic         pt_ready_o,
    input  logic [127:0] pt_data_i,
    output logic         ct_valid_o,
    input  logic         ct_ready_i,
    output logic [127:0] ct_data_o,
    output logic [127:0] aes_state_o,
    output logic [255:0] aes_key_o,
    input  logic [127:0] aes_out_i
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    ctr_state_e       state_q, state_d;
    logic [127:0]     ctr_q, ctr_d;
    logic [127:0]     aes_state_q, aes_state_d;
    logic [255:0]     aes_key_q, aes_key_d;
    logic [15:0]      remaining_q, remaining_d;
    logic [AES_LAT:0] vpipe_q, vpipe_d;
    logic             done_q, done_d;

    logic [CntW-1:0]  pt_count, ks_count;
    logic             pt_empty, ks_empty;
    logic [127:0]     pt_head, ks_head;
    logic             pt_ready, accept, ct_valid, handshake, ks_push;

    // Issue is gated on pt_fifo room: every pt_fifo entry is either in flight or
    // already in ks_fifo, so ks_fifo can never be pushed while full.
    assign pt_ready  = (state_q == StRun) && (pt_count < CntW'(DEPTH));
    assign accept    = pt_valid_i && pt_ready;
    assign ct_valid  = !pt_empty && !ks_empty;
    assign handshake = ct_valid && ct_ready_i;
    assign ks_push   = vpipe_q[AES_LAT];

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        aes_state_d = aes_state_q;
        aes_key_d   = aes_key_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        vpipe_d     = {vpipe_q[AES_LAT-1:0], accept};
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (blk_count_i != 16'd0) begin
                        state_d     = StRun;
                        aes_key_d   = key_i;
                        ctr_d       = iv_i;
                        remaining_d = blk_count_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    aes_state_d = ctr_q;
                    ctr_d       = inc32(ctr_q);
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // No pushes in DRAIN, so popping the last entry ends the job.
                if (handshake && (pt_count == CntW'(1))) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ctr_q       <= '0;
            aes_state_q <= '0;
            aes_key_q   <= '0;
            remaining_q <= '0;
            vpipe_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            aes_state_q <= aes_state_d;
            aes_key_q   <= aes_key_d;
            remaining_q <= remaining_d;
            vpipe_q     <= vpipe_d;
            done_q      <= done_d;
        end
    end

    sync_fifo #(
        .Width (128),
        .Depth (DEPTH)
    ) u_pt_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .wdata_i (pt_data_i),
        .pop_i   (handshake),
        .rdata_o (pt_head),
        .empty_o (pt_empty),
        .count_o (pt_count)
    );

    sync_fifo #(
        .Width (128),
        .Depth (DEPTH)
    ) u_ks_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ks_push),
        .wdata_i (aes_out_i),
        .pop_i   (handshake),
        .rdata_o (ks_head),
        .empty_o (ks_empty),
        .count_o (ks_count)
    );

`ifndef SYNTHESIS
    ks_no_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
        !(ks_push && (ks_count == CntW'(DEPTH))));
`endif

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign pt_ready_o  = pt_ready;
    assign ct_valid_o  = ct_valid;
    assign ct_data_o   = ks_head ^ pt_head;
    assign aes_state_o = aes_state_q;
    assign aes_key_o   = aes_key_q;

endmodule

// File: tb/tb_aes_256_ctr_stage.sv
// Self-checking bench for aes_256_ctr_stage. A behavioural stand-in for aes_256
// (29-stage register pipe) returns the FIPS-197 AES-256 known answer for that
// vector and a keyed mixing function otherwise. Expected ciphertexts are queued
// when each plaintext is issued and checked by an independent output monitor.
module tb_aes_256_ctr_stage;

    localparam int AES_LAT = 29;
    localparam int DEPTH   = 32;

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk, rst, start;
    logic [255:0] key;
    logic [127:0] iv;
    logic [15:0]  blk_count;
    logic         busy, done;
    logic         pt_valid, pt_ready;
    logic [127:0] pt_data;
    logic         ct_valid, ct_ready;
    logic [127:0] ct_data;
    logic [127:0] aes_state;
    logic [255:0] aes_key;
    logic [127:0] aes_out;

    aes_256_ctr_stage #(
        .AES_LAT (AES_LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .key_i       (key),
        .iv_i        (iv),
        .blk_count_i (blk_count),
        .busy_o      (busy),
        .done_o      (done),
        .pt_valid_i  (pt_valid),
        .pt_ready_o  (pt_ready),
        .pt_data_i   (pt_data),
        .ct_valid_o  (ct_valid),
        .ct_ready_i  (ct_ready),
        .ct_data_o   (ct_data),
        .aes_state_o (aes_state),
        .aes_key_o   (aes_key),
        .aes_out_i   (aes_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ks_ref(input logic [127:0] st, input logic [255:0] k);
        if (st == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return st ^ k[255:128] ^ {k[63:0], k[127:64]} ^ {st[95:0], st[127:96]};
    endfunction

    // aes_256 stand-in: samples state/key every edge, output AES_LAT edges later.
    logic [127:0] apipe [AES_LAT];
    always @(posedge clk) begin
        apipe[0] <= ks_ref(aes_state, aes_key);
        for (int i = 1; i < AES_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign aes_out = apipe[AES_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Scoreboard and model state
    logic [127:0] exp_q [$];
    logic [127:0] m_ctr;
    logic [255:0] m_key;
    logic [127:0] pt_base;
    int           pt_idx;
    int           last_acc_cyc;

    // Output monitor
    int  hs_total = 0;
    int  hs_bursts = 0;
    int  done_total = 0;
    bit  prev_hs = 1'b0;
    initial begin
        logic [127:0] e;
        bit hs;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_total++;
            hs = (ct_valid === 1'b1) && (ct_ready === 1'b1);
            if (hs) begin
                hs_total++;
                if (!prev_hs) hs_bursts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ct_unexpected: got %h required no output", ct_data);
                end else begin
                    e = exp_q.pop_front();
                    check("ct_data", 256'(ct_data), 256'(e));
                end
            end
            prev_hs = hs;
        end
    end

    function automatic logic [127:0] pt_pat(input logic [127:0] base, input int i);
        logic [31:0] w;
        w = 32'(i) * 32'h9e3779b9;
        return base ^ {w, w << 3, w >> 5, 32'(i)};
    endfunction

    // All tasks start and end at posedge+#1.
    task automatic start_job(input logic [255:0] k, input logic [127:0] v, input int n);
        m_key = k;
        m_ctr = v;
        pt_idx = 0;
        key = k;
        iv = v;
        blk_count = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive(input int n, input int budget, output int acc, output int stalls);
        acc = 0;
        stalls = 0;
        for (int c = 0; c < budget && acc < n; c++) begin
            pt_valid = 1'b1;
            pt_data = pt_pat(pt_base, pt_idx);
            @(negedge clk);
            if (pt_ready === 1'b1) begin
                exp_q.push_back(ks_ref(m_ctr, m_key) ^ pt_data);
                last_acc_cyc = cyc;
                acc++;
                pt_idx++;
                @(posedge clk); #1;
                check("aes_state", 256'(aes_state), 256'(m_ctr));
                m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
            end else begin
                stalls++;
                @(posedge clk); #1;
            end
        end
        pt_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 256'(got), 256'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int acc, stalls, h0, b0, d0, lat;
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        key = '0;
        iv = '0;
        blk_count = '0;
        pt_valid = 1'b0;
        pt_data = '0;
        ct_ready = 1'b1;
        pt_base = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_pt_ready", 256'(pt_ready), 256'(0));
        check("rst_ct_valid", 256'(ct_valid), 256'(0));
        check("rst_aes_state", 256'(aes_state), 256'(0));
        check("rst_aes_key", aes_key, 256'(0));
        @(posedge clk); #1;

        // FIPS-197 AES-256 vector, single block, zero plaintext
        d0 = done_total;
        start_job(FIPS_KEY, FIPS_PT, 1);
        check("fips_aes_key", aes_key, FIPS_KEY);
        check("fips_busy", 256'(busy), 256'(1));
        drive(1, 10, acc, stalls);
        seen = 1'b0;
        lat = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ct_valid === 1'b1) begin
                seen = 1'b1;
                lat = cyc - last_acc_cyc;
                break;
            end
        end
        check("fips_ct_seen", 256'(seen), 256'(1));
        check("fips_latency", 256'(lat), 256'(31));
        @(posedge clk); #1;
        wait_done("fips_done", 20);
        check("fips_busy_after", 256'(busy), 256'(0));
        check("fips_done_count", 256'(done_total - d0), 256'(1));
        check("fips_sb_empty", 256'(exp_q.size()), 256'(0));

        // Counter wrap: low 32 bits ffffffff -> 0 -> 1, upper 96 fixed
        pt_base = 128'hdeadbeef_00000000_cafef00d_12345678;
        start_job(256'h1, 128'h0123456789abcdef01234567ffffffff, 3);
        drive(3, 20, acc, stalls);
        check("wrap_accepts", 256'(acc), 256'(3));
        wait_done("wrap_done", 80);
        check("wrap_sb_empty", 256'(exp_q.size()), 256'(0));

        // Back-pressure: ct_ready low, 40 blocks, exactly DEPTH accepted
        ct_ready = 1'b0;
        h0 = hs_total;
        d0 = done_total;
        pt_base = 128'h55aa55aa_0f0f0f0f_33cc33cc_10203040;
        start_job({8{32'h76543210}}, 128'hf0e0d0c0_b0a09080_70605040_00000010, 40);
        drive(40, 80, acc, stalls);
        check("bp_accepts", 256'(acc), 256'(DEPTH));
        @(negedge clk);
        check("bp_pt_ready_low", 256'(pt_ready), 256'(0));
        check("bp_ct_valid", 256'(ct_valid), 256'(1));
        @(posedge clk); #1;
        ct_ready = 1'b1;
        drive(8, 200, acc, stalls);
        check("bp_rest_accepts", 256'(acc), 256'(8));
        wait_done("bp_done", 200);
        repeat (3) @(posedge clk);
        #1;
        check("bp_outputs", 256'(hs_total - h0), 256'(40));
        check("bp_done_count", 256'(done_total - d0), 256'(1));
        check("bp_sb_empty", 256'(exp_q.size()), 256'(0));

        // Full-rate streaming: no input stalls, one contiguous output burst
        h0 = hs_total;
        b0 = hs_bursts;
        pt_base = 128'h01010101_02020202_03030303_04040404;
        start_job({4{64'h0badc0de_feedface}}, 128'h11111111_22222222_33333333_fffffff0, 100);
        drive(100, 150, acc, stalls);
        check("stream_accepts", 256'(acc), 256'(100));
        check("stream_stalls", 256'(stalls), 256'(0));
        wait_done("stream_done", 100);
        check("stream_outputs", 256'(hs_total - h0), 256'(100));
        check("stream_bursts", 256'(hs_bursts - b0), 256'(1));

        // Zero-length job: done next cycle, no accepts
        d0 = done_total;
        start_job(256'h5, 128'h6, 0);
        @(negedge clk);
        check("zero_done", 256'(done), 256'(1));
        check("zero_busy", 256'(busy), 256'(0));
        check("zero_pt_ready", 256'(pt_ready), 256'(0));
        @(negedge clk);
        check("zero_done_pulse", 256'(done), 256'(0));
        @(posedge clk); #1;
        check("zero_done_count", 256'(done_total - d0), 256'(1));

        // start during RUN is ignored
        h0 = hs_total;
        pt_base = 128'h99999999_88888888_77777777_66666666;
        start_job({2{128'h00ff00ff_11ee11ee_22dd22dd_33cc33cc}}, 128'h0a0b0c0d_00000000_00000000_00000100, 2);
        drive(1, 10, acc, stalls);
        key = {8{32'hffffffff}};
        iv = '0;
        blk_count = 16'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_key_held", aes_key, m_key);
        check("busy_still_run", 256'(busy), 256'(1));
        drive(1, 10, acc, stalls);
        @(negedge clk);
        check("busy_drain_pt_ready", 256'(pt_ready), 256'(0));
        @(posedge clk); #1;
        wait_done("busy_done", 80);
        check("busy_outputs", 256'(hs_total - h0), 256'(2));

        // Reset mid-job after 10 accepts
        pt_base = 128'h13579bdf_2468ace0_fdb97531_0eca8642;
        start_job({8{32'h0c0ffee0}}, 128'hc0000000_00000000_00000000_00000000, 20);
        drive(10, 20, acc, stalls);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_pt_ready", 256'(pt_ready), 256'(0));
        check("mid_rst_ct_valid", 256'(ct_valid), 256'(0));
        check("mid_rst_aes_state", 256'(aes_state), 256'(0));
        check("mid_rst_aes_key", aes_key, 256'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        h0 = hs_total;
        d0 = done_total;
        pt_base = 128'h0;
        start_job({8{32'h1badd00d}}, 128'h00000000_00000000_00000000_00000001, 5);
        drive(5, 20, acc, stalls);
        wait_done("post_rst_done", 80);
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_outputs", 256'(hs_total - h0), 256'(5));
        check("post_rst_done_count", 256'(done_total - d0), 256'(1));
        check("post_rst_sb_empty", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_256_ctr_stage.md
# aes_256_ctr_stage

CTR-mode wrapper that sits directly upstream and downstream of the free-running, non-stallable `aes_256` pipeline. It latches a 256-bit key and a 128-bit initial counter. For each accepted plaintext block it issues one counter block into `aes_256`. It tracks each block's flight through the fixed-latency pipeline with a valid shift register, buffers the returning keystream, and emits ciphertext = keystream XOR plaintext over a ready/valid handshake. Back-pressure is absorbed by credit-limited issue, so no keystream word is ever dropped.

## Interface
Parameters:
- `AES_LAT`, 29: `aes_256` latency in cycles, from state/key sampled to `out` valid.
- `DEPTH`, 32: entries in the plaintext FIFO and the keystream FIFO. Must be a power of 2 and ≥ `AES_LAT`+2 for full throughput.

Ports:
- `clk`  in  1  clock. One clock domain; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle job request; honoured only in IDLE.
- `key`  in  256  job key, sampled on `start`.
- `iv`  in  128  initial counter block, sampled on `start`.
- `blk_count`  in  16  number of blocks in the job, sampled on `start`.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse when the last ciphertext block is handed off.
- `pt_valid`  in  1  plaintext block available.
- `pt_ready`  out  1  plaintext accepted this cycle when `pt_valid` is also high.
- `pt_data`  in  128  plaintext block.
- `ct_valid`  out  1  ciphertext block available.
- `ct_ready`  in  1  downstream accepts the ciphertext block.
- `ct_data`  out  128  ciphertext block.
- `aes_state`  out  128  counter block driven to `aes_256` `state`.
- `aes_key`  out  256  key driven to `aes_256` `key`.
- `aes_out`  in  128  keystream returned from `aes_256` `out`.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN: on `start` with `blk_count` ≠ 0.
  - Latch `key` into `aes_key`, `iv` into `ctr`, and `blk_count` into `remaining`.
- IDLE on `start` with `blk_count` = 0: pulse `done` the next cycle and stay in IDLE.
- RUN, accept condition: `pt_ready` = (`pt_fifo` count < `DEPTH`). Accept = `pt_valid` & `pt_ready`.
- RUN, on each accept:
  - Push `pt_data` into `pt_fifo`.
  - Register `aes_state` <= `ctr`.
  - Shift a 1 into `vpipe`; cycles without an accept shift in a 0.
  - Update `ctr` <= {`ctr`[127:32], `ctr`[31:0]+1}. The low 32 bits wrap modulo 2^32; the upper 96 bits never change.
  - Decrement `remaining`.
- RUN → DRAIN: on the accept that takes `remaining` from 1 to 0. `pt_ready` is 0 in DRAIN and IDLE.
- Keystream capture: when the `vpipe` tap (depth `AES_LAT`+1) is 1, push `aes_out` into `ks_fifo`.
- Credit rule: `pt_fifo` count = blocks in flight + `ks_fifo` count. Gating issue on `pt_fifo` room therefore guarantees `ks_fifo` never overflows. A `ks_fifo` push while full is an assertion failure.
- Output:
  - `ct_valid` = both FIFOs non-empty.
  - `ct_data` = `ks_fifo` head XOR `pt_fifo` head.
  - A `ct_valid` & `ct_ready` handshake pops both FIFOs together.
- DRAIN → IDLE: on the handshake that empties `pt_fifo`. `done` pulses in the cycle after that handshake edge.
- `aes_key` is held constant from `start` until the next `start`.
- `start` while `busy` is ignored.
- Reset values:
  - State = IDLE.
  - `ctr`, `remaining`, `aes_state`, `aes_key` = 0.
  - `vpipe` cleared, both FIFOs empty.
  - `busy`, `done`, `pt_ready`, `ct_valid` = 0.
- Reset mid-job: the above applies. Stale `aes_256` contents are discarded because `vpipe` is zero.

## Timing
- Throughput: one block per cycle while `ct_ready` is high and `DEPTH` ≥ `AES_LAT`+2.
- Latency: a plaintext accepted at edge e0 gives `aes_state` valid in the following cycle, sampled by `aes_256` at e1. The keystream is pushed into `ks_fifo` at e(`AES_LAT`+1). `ct_valid` is high in the cycle after that edge, i.e. `AES_LAT`+2 = 31 cycles after the accept cycle with defaults.
- FIFOs:
  - Registered write.
  - Combinational head read.
  - Simultaneous push and pop when full or empty are legal.
  - Count is `$clog2(DEPTH)+1` bits.
- `ct_data` is stable while `ct_valid` & !`ct_ready`.

## Structure
- Package `aes_ctr_pkg`:
  - State enum.
  - `inc32` function.
  - Default `AES_LAT`/`DEPTH` constants.
- Sub-module `sync_fifo`, parameterised on width and depth, instantiated twice (128-bit `pt_fifo`, 128-bit `ks_fifo`).
- `aes_256` is instantiated by the parent alongside this block, not inside it.

## Test plan
- FIPS-197 vector:
  - Stimulus: `key` = 000102…1f, `iv` = 00112233445566778899aabbccddeeff, `blk_count` = 1, `pt` = 0.
  - Required: `ct_data` = 8ea2b7ca516745bfeafc49904b496089, valid 31 cycles after accept, then a `done` pulse.
- Counter wrap:
  - Stimulus: `iv` low32 = ffffffff, `blk_count` = 3.
  - Required: `aes_state` low32 sequence ffffffff, 00000000, 00000001; upper 96 bits unchanged; ciphertext matches a reference model.
- Back-pressure:
  - Stimulus: `ct_ready` = 0, `blk_count` = 40, `pt_valid` held high.
  - Required: exactly 32 accepts, then `pt_ready` = 0; no `ks_fifo` overflow.
  - Then release `ct_ready`: all 40 blocks emerge in order and `done` pulses once.
- Full-rate streaming:
  - Stimulus: `blk_count` = 100 with `ct_ready` = 1.
  - Required: `pt_ready` never drops; output has no gaps after the first block.
- Zero-length job and busy behaviour:
  - Required: `blk_count` = 0 gives a `done` pulse one cycle after `start` with no accepts.
  - Required: a `start` during RUN is ignored.
- Reset mid-job:
  - Stimulus: assert `rst` after 10 accepts.
  - Required: outputs return to reset values immediately; a subsequent job yields correct ciphertext with no stale blocks.
